// File: rtl/mux_n_pipe_pkg.sv
// Shared types for the N-way registered selector: skid buffer occupancy
// states and the out-of-range select test.
package mux_n_pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic logic sel_out_of_range(input int sel, input int num_in);
    return sel >= num_in;
  endfunction

endpackage

// File: rtl/mux_n_pipe_skid_buffer.sv
// Two-entry skid buffer with a registered in_ready; words leave in the order
// they were accepted. Reusable for any stage boundary with backpressure.
module mux_n_pipe_skid_buffer
  import mux_n_pipe_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state_p1, state_nxt;
  logic [W-1:0] main_p1;
  logic [W-1:0] skid_p1;
  logic         accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      SKID_EMPTY: if (accept) state_nxt = SKID_ONE;
      SKID_ONE: begin
        if (accept && !out_ready)      state_nxt = SKID_FULL;
        else if (!accept && out_ready) state_nxt = SKID_EMPTY;
      end
      SKID_FULL: if (out_ready) state_nxt = SKID_ONE;
      default:   state_nxt = SKID_EMPTY;
    endcase
  end

  // Stage p1: main/skid storage and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= SKID_EMPTY;
      main_p1  <= '0;
      skid_p1  <= '0;
      in_ready <= 1'b1;
    end else begin
      state_p1 <= state_nxt;
      in_ready <= (state_nxt != SKID_FULL);
      case (state_p1)
        SKID_EMPTY: if (accept) main_p1 <= in_data;
        SKID_ONE: begin
          if (accept && out_ready) main_p1 <= in_data;
          else if (accept)         skid_p1 <= in_data;
        end
        SKID_FULL: if (out_ready) main_p1 <= skid_p1;
        default: ;
      endcase
    end
  end

  assign out_data  = main_p1;
  assign out_valid = (state_p1 != SKID_EMPTY);

endmodule

// File: rtl/mux_n_pipe.sv
// Parametrised NUM_IN-way, N-bit selector whose result crosses a registered
// valid/ready boundary; out-of-range selects are flagged per word and sticky.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int N        = 32,
  parameter int NUM_IN   = 5,
  parameter int SEL_W    = 3,
  parameter int ERR_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IN*N-1:0] in_bus,
  input  logic [SEL_W-1:0]    select,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sel_err,
  output logic                err_sticky,
  input  logic                err_clr
);

  if (NUM_IN < 2 || (1 << SEL_W) < NUM_IN) begin : g_param_check
    $error("mux_n_pipe: NUM_IN must be >= 2 and fit in SEL_W select bits");
  end

  logic [N-1:0] sel_word_p0;
  logic         sel_err_p0;
  logic         accept_p0;
  logic [N:0]   buf_out_p1;

  assign sel_err_p0 = sel_out_of_range(int'(select), NUM_IN);
  assign accept_p0  = in_valid && in_ready;

  // Stage p0: combinational selection in the accept cycle
  always_comb begin
    sel_word_p0 = (ERR_ZERO != 0) ? '0 : in_bus[0 +: N];
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(select) == k) sel_word_p0 = in_bus[k*N +: N];
    end
  end

  mux_n_pipe_skid_buffer #(
    .W(N + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_err_p0, sel_word_p0}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (buf_out_p1),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_sel_err = buf_out_p1[N];
  assign out_data    = buf_out_p1[N-1:0];

  // Stage p1: sticky error flag, a same-cycle set beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_sticky <= 1'b0;
    else if (accept_p0 && sel_err_p0) err_sticky <= 1'b1;
    else if (err_clr)                 err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed scenarios on two 5x32 instances (ERR_ZERO 1/0)
// and a randomized 16x8 instance checked against a queue-based reference.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance A: N=32, NUM_IN=5, ERR_ZERO=1
  logic [159:0] a_bus = '0;
  logic [2:0]   a_sel = '0;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic a_sel_err, a_sticky, a_clr = 0;
  logic [31:0]  a_data;

  // Instance B: same shape, ERR_ZERO=0
  logic [159:0] b_bus = '0;
  logic [2:0]   b_sel = '0;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic b_sel_err, b_sticky, b_clr = 0;
  logic [31:0]  b_data;
  logic [31:0]  b_words [5];

  // Instance C: N=8, NUM_IN=16, SEL_W=4
  logic [127:0] c_bus = '0;
  logic [3:0]   c_sel = '0;
  logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic c_sel_err, c_sticky, c_clr = 0;
  logic [7:0]   c_data;

  mux_n_pipe #(.N(32), .NUM_IN(5), .SEL_W(3), .ERR_ZERO(1)) dut_a (
    .clk(clk), .rst(rst), .in_bus(a_bus), .select(a_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sel_err(a_sel_err), .err_sticky(a_sticky),
    .err_clr(a_clr));

  mux_n_pipe #(.N(32), .NUM_IN(5), .SEL_W(3), .ERR_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .in_bus(b_bus), .select(b_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sel_err(b_sel_err), .err_sticky(b_sticky),
    .err_clr(b_clr));

  mux_n_pipe #(.N(8), .NUM_IN(16), .SEL_W(4), .ERR_ZERO(1)) dut_c (
    .clk(clk), .rst(rst), .in_bus(c_bus), .select(c_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_sel_err(c_sel_err), .err_sticky(c_sticky),
    .err_clr(c_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({a_out_valid, a_sel_err, a_sticky} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {a_out_valid, a_sel_err, a_sticky});
    else pass_cnt++;
    total_cnt++;
    if (a_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", a_data);
    else pass_cnt++;
    total_cnt++;
    if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready_held: got %b expected 1", a_in_ready);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("FAIL reset_after_release: in_ready/out_valid got %b%b expected 10", a_in_ready, a_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 5; k++) a_bus[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    a_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_sel = 3'(k);
      a_in_valid = 1'b1;
      tick();
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_data !== 32'hA000_0000 + 32'(k) || a_sel_err !== 1'b0)
        $display("FAIL stream_word%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0", k, a_out_valid, a_data, a_sel_err, 32'hA000_0000 + 32'(k));
      else pass_cnt++;
    end
    a_in_valid = 1'b0;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_sticky !== 1'b0) $display("FAIL stream_idle: got v=%b sticky=%b expected 0 0", a_out_valid, a_sticky);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_sel = 3'd1;
    tick();
    total_cnt++;
    if (a_in_ready !== 1'b1 || a_data !== exp_seq[0]) $display("FAIL bp_first: rdy=%b d=%h expected rdy=1 d=%h", a_in_ready, a_data, exp_seq[0]);
    else pass_cnt++;
    a_sel = 3'd2;
    tick();
    total_cnt++;
    if (a_in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", a_in_ready);
    else pass_cnt++;
    a_sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_data !== exp_seq[0] || a_sel_err !== 1'b0)
        $display("FAIL bp_stall%0d: rdy=%b v=%b d=%h expected rdy=0 v=1 d=%h", i, a_in_ready, a_out_valid, a_data, exp_seq[0]);
      else pass_cnt++;
    end
    a_out_ready = 1'b1;
    tick();
    total_cnt++;
    if (a_data !== exp_seq[1] || a_in_ready !== 1'b1) $display("FAIL bp_second: d=%h rdy=%b expected d=%h rdy=1", a_data, a_in_ready, exp_seq[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_data !== exp_seq[2] || a_out_valid !== 1'b1) $display("FAIL bp_third: d=%h v=%b expected d=%h v=1", a_data, a_out_valid, exp_seq[2]);
    else pass_cnt++;
    a_in_valid = 1'b0;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b0) $display("FAIL bp_drained: got v=%b expected 0", a_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_oor_zero();
    a_out_ready = 1'b1;
    for (int s = 5; s < 8; s++) begin
      a_sel = 3'(s);
      a_in_valid = 1'b1;
      tick();
      total_cnt++;
      if (a_data !== 32'h0 || a_sel_err !== 1'b1 || a_sticky !== 1'b1 || a_out_valid !== 1'b1)
        $display("FAIL oor_zero_sel%0d: d=%h e=%b sticky=%b v=%b expected 0 1 1 1", s, a_data, a_sel_err, a_sticky, a_out_valid);
      else pass_cnt++;
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_oor_input0();
    for (int k = 0; k < 5; k++) begin
      b_words[k] = $urandom;
      b_bus[k*32 +: 32] = b_words[k];
    end
    b_out_ready = 1'b1;
    for (int s = 5; s < 8; s++) begin
      b_sel = 3'(s);
      b_in_valid = 1'b1;
      tick();
      total_cnt++;
      if (b_data !== b_words[0] || b_sel_err !== 1'b1 || b_sticky !== 1'b1)
        $display("FAIL oor_input0_sel%0d: d=%h e=%b sticky=%b expected d=%h e=1 sticky=1", s, b_data, b_sel_err, b_sticky, b_words[0]);
      else pass_cnt++;
    end
    b_sel = 3'd3;
    tick();
    total_cnt++;
    if (b_data !== b_words[3] || b_sel_err !== 1'b0) $display("FAIL b_in_range: d=%h e=%b expected d=%h e=0", b_data, b_sel_err, b_words[3]);
    else pass_cnt++;
    b_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_err_clr();
    a_out_ready = 1'b1;
    a_in_valid = 1'b0;
    a_clr = 1'b1;
    tick();
    total_cnt++;
    if (a_sticky !== 1'b0) $display("FAIL clr_alone: got %b expected 0", a_sticky);
    else pass_cnt++;
    a_sel = 3'd7;
    a_in_valid = 1'b1;
    tick();
    total_cnt++;
    if (a_sticky !== 1'b1 || a_sel_err !== 1'b1) $display("FAIL clr_vs_set: sticky=%b e=%b expected 1 1", a_sticky, a_sel_err);
    else pass_cnt++;
    a_sel = 3'd2;
    tick();
    total_cnt++;
    if (a_sticky !== 1'b0 || a_sel_err !== 1'b0) $display("FAIL clr_in_range: sticky=%b e=%b expected 0 0", a_sticky, a_sel_err);
    else pass_cnt++;
    a_clr = 1'b0;
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_sel = 3'd6;
    tick();
    a_sel = 3'd2;
    tick();
    a_in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_sticky !== 1'b1) $display("FAIL midrst_setup: v=%b rdy=%b sticky=%b expected 1 0 1", a_out_valid, a_in_ready, a_sticky);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_sticky !== 1'b0 || a_data !== 32'h0) $display("FAIL midrst_async: v=%b sticky=%b d=%h expected 0 0 0", a_out_valid, a_sticky, a_data);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    a_out_ready = 1'b1;
    tick();
    total_cnt++;
    if (a_in_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", a_in_ready);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b0) $display("FAIL midrst_stale: got v=%b d=%h expected no word", a_out_valid, a_data);
    else pass_cnt++;
    a_sel = 3'd4;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_data !== 32'hA000_0004) $display("FAIL midrst_resume: v=%b d=%h expected 1 a0000004", a_out_valid, a_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [8:0] sb [$];
    logic [8:0] exp_w;
    int mism = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) c_bus[k*32 +: 32] = $urandom;
      c_sel = 4'($urandom_range(0, 15));
      c_in_valid = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      total_cnt++;
      if (c_out_valid !== (sb.size() > 0) || c_in_ready !== (sb.size() < 2)) begin
        $display("FAIL rand_flow cyc%0d: v=%b rdy=%b with %0d queued", i, c_out_valid, c_in_ready, sb.size());
        mism++;
      end else pass_cnt++;
      if (c_out_valid && c_out_ready && sb.size() > 0) begin
        exp_w = sb.pop_front();
        total_cnt++;
        if ({c_sel_err, c_data} !== exp_w) begin
          $display("FAIL rand_data cyc%0d: got e=%b d=%h expected e=%b d=%h", i, c_sel_err, c_data, exp_w[8], exp_w[7:0]);
          mism++;
        end else pass_cnt++;
      end
      if (c_in_valid && c_in_ready) sb.push_back({1'b0, c_bus[int'(c_sel)*8 +: 8]});
      if (mism > 20) break;
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (c_out_valid && sb.size() > 0) begin
        exp_w = sb.pop_front();
        total_cnt++;
        if ({c_sel_err, c_data} !== exp_w) $display("FAIL rand_drain: got %h expected %h", {c_sel_err, c_data}, exp_w);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (sb.size() != 0 || c_out_valid !== 1'b0 || c_sticky !== 1'b0) $display("FAIL rand_end: %0d words undelivered, v=%b sticky=%b", sb.size(), c_out_valid, c_sticky);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_oor_zero();
    test_oor_input0();
    test_err_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage and valid/ready flow control; generalises the fixed 5:1 datapath selector.
- Feeds MIPS pipeline datapaths (ALU operand select, writeback select) wherever the selected value must cross a stage boundary with backpressure.
- A 2-entry skid buffer keeps `in_ready` a registered signal.
- Out-of-range selects are flagged instead of being silently zeroed.

Parameters:
- N, 32, data width in bits.
- NUM_IN, 5, number of inputs (2..16).
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NUM_IN.
- ERR_ZERO, 1:
  - 1: an out-of-range select passes all-zero data.
  - 0: an out-of-range select passes input 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_bus  input  NUM_IN*N  packed inputs; input k is bits [k*N +: N].
- select  input  SEL_W  input index, sampled with in_valid.
- in_valid  input  1  upstream has a select/data pair.
- in_ready  output  1  block can accept; registered.
- out_data  output  N  selected word; registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_sel_err  output  1  current output word came from an out-of-range select.
- err_sticky  output  1  set by any accepted out-of-range select.
- err_clr  input  1  synchronous clear of err_sticky.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst is asynchronous and active-high.
  - All state clears on rst assertion, independent of clk.
- Reset values:
  - out_data = 0, out_valid = 0, out_sel_err = 0, err_sticky = 0.
  - in_ready = 1 on the first edge after deassertion and while reset is held.
  - Both skid entries are empty.
- Accept and deliver:
  - Accept occurs on a cycle with in_valid && in_ready.
  - The selection is computed combinationally from in_bus/select in the accept cycle; only the selected word plus its error bit is stored.
- Latency:
  - 1 cycle from accept to out_valid when the buffer is empty and out_ready is held high.
  - Sustained throughput is 1 word/cycle with out_ready = 1.
- Out-of-range select:
  - Condition: select >= NUM_IN.
  - The data word follows ERR_ZERO.
  - out_sel_err = 1 travels with that word.
  - err_sticky sets on the accept edge.
- Skid buffer states: EMPTY (0 words), ONE (main register valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE, with accept and out_ready: stay ONE; main is replaced.
  - ONE, with accept and !out_ready: -> FULL; the new word goes to skid.
  - ONE, with out_ready and no accept: -> EMPTY.
  - FULL, with out_ready: skid moves to main -> ONE.
  - FULL, with !out_ready: hold.
  - in_ready = (next state != FULL), registered.
- Ordering:
  - Words exit strictly in accept order.
  - No word is dropped or duplicated under any out_ready pattern.
- Output stability: while out_valid && !out_ready, out_data and out_sel_err stay stable.
- Simultaneous events:
  - err_clr with a same-cycle out-of-range accept: set wins; err_sticky = 1 next cycle.
  - err_clr alone: err_sticky = 0 next cycle.
- Mid-operation reset: rst asserted mid-stream discards all buffered words immediately; out_valid falls asynchronously.
- Parameter errors:
  - NUM_IN < 2 or 2^SEL_W < NUM_IN is an elaboration error.
  - Detection is by a generate-time check.

Decomposition:
- Shared constants go in a new mux_defines.v alongside alu_defines.v: the skid state encodings `MUX_SKID_EMPTY`, `MUX_SKID_ONE` and `MUX_SKID_FULL`.
- The combinational N-way selector is a for-loop inside mux_n_pipe.
- One natural sub-module, skid_buffer:
  - Parametrised on width N+1 (data + err bit).
  - Holds the state machine and the registered in_ready.
  - Reusable by other pipeline stages.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-stream with 2 words buffered.
  - Required: out_valid = 0 immediately, err_sticky = 0, in_ready = 1 after deassert.
  - Required: no stale word emerges afterwards.
- Streaming:
  - Stimulus: NUM_IN=5, N=32, in_bus k = 32'hA000_000k, select cycles 0..4, out_ready = 1.
  - Required: out_data sequence A0000000..A0000004, each one cycle after accept.
- Backpressure:
  - Stimulus: accept selects 1, 2, 3 with out_ready held 0.
  - Required: in_ready falls after 2 accepts; the 3rd is not accepted until out_ready = 1.
  - Required: output order is 1, 2, 3, and out_data is stable while stalled.
- Out-of-range select:
  - Stimulus: select = 5, 6, 7 with ERR_ZERO=1.
  - Required: out_data = 0, out_sel_err = 1, err_sticky = 1.
  - Stimulus: repeat with ERR_ZERO=0.
  - Required: out_data = input 0.
- Error clear:
  - Stimulus: err_clr alone.
  - Required: err_sticky = 0 next cycle.
  - Stimulus: err_clr in the same cycle as a select = 7 accept.
  - Required: err_sticky = 1.
- Random:
  - Stimulus: NUM_IN=16, SEL_W=4, N=8; random in_valid/out_ready for 10k cycles against a scoreboard queue.
  - Required: zero mismatches, no drops or duplicates.
